// File: rtl/tx_arbiter.sv
// Two-requester round-robin arbiter feeding a byte-wide transmit engine.
// One Write/ack per frame, then waits out the engine and an inter-frame gap.
`timescale 1ns/1ps
module tx_arbiter #(
   parameter int GAP_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [7:0]       data0,
   input  logic             req1,
   input  logic [7:0]       data1,
   input  logic [GAP_W-1:0] gap,
   input  logic             TXRDY,
   output logic             Write,
   output logic [7:0]       OUT_PORT,
   output logic             ack0,
   output logic             ack1,
   output logic             owner,
   output logic             busy
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, GAP} state_t;

   state_t           state, state_nx;
   logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;
   logic             owner_nx;
   logic [7:0]       out_nx;
   logic             grant_sel;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         gap_cnt  <= '0;
         owner    <= 1'b1;
         OUT_PORT <= 8'h00;
      end else begin
         state    <= state_nx;
         gap_cnt  <= gap_cnt_nx;
         owner    <= owner_nx;
         OUT_PORT <= out_nx;
      end
   end

   // With both requesting, the one that did not win last time goes next.
   assign grant_sel = (req0 & req1) ? ~owner : req1;

   always_comb begin
      state_nx   = state;
      gap_cnt_nx = gap_cnt;
      owner_nx   = owner;
      out_nx     = OUT_PORT;
      Write      = 1'b0;
      ack0       = 1'b0;
      ack1       = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (TXRDY && (req0 || req1)) begin
               owner_nx = grant_sel;
               out_nx   = grant_sel ? data1 : data0;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            Write    = 1'b1;
            ack0     = ~owner;
            ack1     = owner;
            state_nx = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!TXRDY) state_nx = WAIT_HIGH;
         end
         WAIT_HIGH: begin
            // gap is captured only here, so edits during GAP do not stretch it.
            if (TXRDY) begin
               if (gap == '0) begin
                  state_nx = IDLE;
               end else begin
                  gap_cnt_nx = gap;
                  state_nx   = GAP;
               end
            end
         end
         GAP: begin
            if (gap_cnt <= GAP_W'(1)) begin
               gap_cnt_nx = '0;
               state_nx   = IDLE;
            end else begin
               gap_cnt_nx = gap_cnt - GAP_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
